// File: rtl/timer_entry_control_pkg.sv
// Shared constants, FSM state encoding and the keypad priority encoder for
// the microwave timer keypad-entry path.
package timer_entry_control_pkg;

    localparam int DIGIT_W  = 4;   // bits per BCD digit
    localparam int NUM_KEYS = 10;  // decimal keypad keys 0..9

    typedef logic [DIGIT_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } key_state_e;

    // Index of the highest pressed key; 0 when nothing is pressed.
    function automatic bcd_t highest_key(input logic [NUM_KEYS-1:0] kpad);
        bcd_t code;
        code = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (kpad[i]) code = bcd_t'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/div_freq_param.sv
// Free-running DIV_RATIO divider with synchronous clear. Exposes the level
// the square wave takes after the coming edge so the parent can register it
// alongside its other outputs.
module div_freq_param #(
    parameter int DIV_RATIO = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic high_next
);

    localparam int CW = (DIV_RATIO > 2) ? $clog2(DIV_RATIO) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV_RATIO - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV_RATIO / 2);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // Next count: held at zero while cleared, otherwise 0..DIV_RATIO-1 wrap.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        cnt_nxt = '0;
        if (!clr) begin
            cnt_nxt = (cnt == LAST) ? '0 : cnt + CW'(1);
        end
        high_next = (cnt_nxt >= HALF);
    end

    // Divider count register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (rst) cnt <= '0;
        else     cnt <= cnt_nxt;
    end

endmodule

// File: rtl/timer_entry_control.sv
// Keypad debounce / BCD entry register / 1 Hz time base for the microwave
// timer. In entry mode CLK_1HZ mirrors the key-accept strobe; in run mode it
// is the divided square wave.
module timer_entry_control
    import timer_entry_control_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int DIV_RATIO       = 100
) (
    input  logic                          CLK_100HZ,
    input  logic                          RST,
    input  logic [NUM_KEYS-1:0]           KPAD,
    input  logic                          EN_N,
    input  logic                          CLR,
    output logic [DIGIT_W-1:0]            D,
    output logic [DIGIT_W*NUM_DIGITS-1:0] DIGITS,
    output logic                          LOAD_N,
    output logic                          CLK_1HZ
);

    localparam int DW = DIGIT_W * NUM_DIGITS;
    localparam logic [7:0] DEB_LIMIT = 8'(DEBOUNCE_CYCLES);

    key_state_e state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    bcd_t       code_q, code_nxt;
    bcd_t       key_code;
    logic       pressed;
    logic       accept;
    logic       div_high_next;

    logic [DW-1:0] digits_nxt;
    bcd_t          d_nxt;
    logic          load_n_nxt;
    logic          clk_1hz_nxt;

    assign pressed  = |KPAD;
    assign key_code = highest_key(KPAD);

    div_freq_param #(
        .DIV_RATIO (DIV_RATIO)
    ) u_div (
        .clk       (CLK_100HZ),
        .rst       (RST),
        .clr       (~EN_N),
        .high_next (div_high_next)
    );

    // FSM state, debounce counter and latched key code.
    always_ff @(posedge CLK_100HZ) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            code_q <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            code_q <= code_nxt;
        end
    end

    // Debounce transitions; a count reaching the limit accepts a press or
    // completes a release.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        code_nxt  = code_q;
        accept    = 1'b0;
        if (EN_N) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pressed) begin
                        code_nxt  = key_code;
                        cnt_nxt   = 8'd1;
                        state_nxt = DEB_PRESS;
                    end
                end
                DEB_PRESS: begin
                    if (!pressed) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (key_code != code_q) begin
                        code_nxt = key_code;
                        cnt_nxt  = 8'd1;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        cnt_nxt   = 8'd1;
                        state_nxt = DEB_RELEASE;
                    end
                end
                DEB_RELEASE: begin
                    if (pressed) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
            if (state_nxt == DEB_PRESS && cnt_nxt == DEB_LIMIT) begin
                accept    = 1'b1;
                state_nxt = HELD;
                cnt_nxt   = '0;
            end else if (state_nxt == DEB_RELEASE && cnt_nxt == DEB_LIMIT) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        end
    end

    // Output values for the coming edge; clear beats the shift on collision.
    always_comb begin
        d_nxt       = accept ? code_nxt : D;
        load_n_nxt  = ~accept;
        clk_1hz_nxt = EN_N ? div_high_next : accept;
        digits_nxt  = DIGITS;
        if (CLR)         digits_nxt = '0;
        else if (accept) digits_nxt = (DIGITS << DIGIT_W) | DW'(code_nxt);
    end

    // Registered outputs.
    always_ff @(posedge CLK_100HZ) begin
        if (RST) begin
            D       <= '0;
            DIGITS  <= '0;
            LOAD_N  <= 1'b1;
            CLK_1HZ <= 1'b0;
        end else begin
            D       <= d_nxt;
            DIGITS  <= digits_nxt;
            LOAD_N  <= load_n_nxt;
            CLK_1HZ <= clk_1hz_nxt;
        end
    end

endmodule

// File: tb/tb_timer_entry_control.sv
// Directed bench for timer_entry_control with hand-computed expectations.
module tb_timer_entry_control;

    logic        clk;
    logic        rst;
    logic [9:0]  kpad;
    logic        en_n;
    logic        clr;
    logic [3:0]  d;
    logic [15:0] digits;
    logic        load_n;
    logic        clk_1hz;

    int n_checks = 0;
    int n_pass   = 0;
    int strobes  = 0;

    timer_entry_control #(
        .NUM_DIGITS      (4),
        .DEBOUNCE_CYCLES (8),
        .DIV_RATIO       (100)
    ) dut (
        .CLK_100HZ (clk),
        .RST       (rst),
        .KPAD      (kpad),
        .EN_N      (en_n),
        .CLR       (clr),
        .D         (d),
        .DIGITS    (digits),
        .LOAD_N    (load_n),
        .CLK_1HZ   (clk_1hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count load strobes, sampled mid-cycle.
    always @(negedge clk) begin
        if (load_n == 1'b0) strobes++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_key(input int k);
        kpad = 10'(1 << k);
        tick(10);
        kpad = '0;
        tick(10);
    endtask

    initial begin
        rst = 1'b1; kpad = '0; en_n = 1'b0; clr = 1'b0;
        tick(2);
        check("rst_d", 32'(d), 32'h0);
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_load_n", 32'(load_n), 32'h1);
        check("rst_clk1hz", 32'(clk_1hz), 32'h0);
        rst = 1'b0;
        tick(1);

        // Clean entry: key 5 then key 0.
        strobes = 0;
        kpad = 10'h020;
        tick(7);
        check("pre_accept_load_n", 32'(load_n), 32'h1);
        tick(1);
        check("accept_load_n", 32'(load_n), 32'h0);
        check("accept_d5", 32'(d), 32'h5);
        check("accept_clk1hz", 32'(clk_1hz), 32'h1);
        tick(1);
        check("strobe_one_cycle", 32'(load_n), 32'h1);
        tick(11);
        kpad = '0;
        tick(10);
        press_key(0);
        check("entry_digits", 32'(digits), 32'h0050);
        check("entry_strobes", 32'(strobes), 32'd2);
        check("entry_d0", 32'(d), 32'h0);

        // Bounce on key 3.
        strobes = 0;
        for (int i = 0; i < 5; i++) begin
            kpad = 10'h008; tick(3);
            kpad = 10'h000; tick(3);
        end
        check("bounce_no_strobe", 32'(strobes), 32'd0);
        kpad = 10'h008;
        tick(7);
        check("bounce_pre_load_n", 32'(load_n), 32'h1);
        tick(1);
        check("bounce_load_n", 32'(load_n), 32'h0);
        check("bounce_d3", 32'(d), 32'h3);
        kpad = '0;
        tick(10);
        check("bounce_digits", 32'(digits), 32'h0503);

        // Priority and overflow.
        kpad = 10'h300;
        tick(10);
        check("priority_d9", 32'(d), 32'h9);
        kpad = '0;
        tick(10);
        for (int k = 1; k <= 5; k++) press_key(k);
        check("overflow_digits", 32'(digits), 32'h2345);

        // Run mode.
        strobes = 0;
        en_n = 1'b1;
        tick(49);
        check("run_pre_rise", 32'(clk_1hz), 32'h0);
        tick(1);
        check("run_first_rise", 32'(clk_1hz), 32'h1);
        kpad = 10'h040;
        tick(49);
        check("run_high_end", 32'(clk_1hz), 32'h1);
        tick(1);
        check("run_fall", 32'(clk_1hz), 32'h0);
        tick(49);
        check("run_low_end", 32'(clk_1hz), 32'h0);
        tick(1);
        check("run_second_rise", 32'(clk_1hz), 32'h1);
        check("run_no_strobe", 32'(strobes), 32'd0);
        check("run_digits_kept", 32'(digits), 32'h2345);
        check("run_load_n", 32'(load_n), 32'h1);
        kpad = '0;
        en_n = 1'b0;
        tick(2);
        check("entry_clk1hz_low", 32'(clk_1hz), 32'h0);

        // CLR in the accept cycle of key 7.
        strobes = 0;
        kpad = 10'h080;
        tick(7);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr_load_n", 32'(load_n), 32'h0);
        check("clr_d7", 32'(d), 32'h7);
        check("clr_digits", 32'(digits), 32'h0);
        kpad = '0;
        tick(10);
        check("clr_strobes", 32'(strobes), 32'd1);

        // Reset in the middle of press debounce.
        strobes = 0;
        kpad = 10'h002;
        tick(4);
        rst = 1'b1;
        tick(2);
        kpad = '0;
        rst = 1'b0;
        tick(12);
        check("rst_mid_strobes", 32'(strobes), 32'd0);
        check("rst_mid_d", 32'(d), 32'h0);
        check("rst_mid_digits", 32'(digits), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
